// File: rtl/mem_req_sequencer_if.sv
// Bundle of every client-side and mem_top-side handshake/bus signal of the
// request sequencer. "master" is the sequencer's own view; "slave" is the
// view of whatever sits around it (client plus mem_top, or a testbench).
interface mem_req_sequencer_if;
    // client request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [1:0]  req_src;
    // client write-payload stream
    logic        wdata_valid;
    logic        wdata_ready;
    logic [7:0]  wdata;
    // client read-payload stream
    logic        rdata_valid;
    logic        rdata_ready;
    logic [7:0]  rdata;
    // completion report
    logic        done;
    logic        done_err;
    // mem_top inbound bus (DATA_IN / VALID_IN / READY_IN)
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    // mem_top outbound bus (DATA / VALID / READY)
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    // mem_top ack channel (ACK_VALID / ACK_READY / MODULE_SOURCE_ID)
    logic        ack_valid;
    logic        ack_ready;
    logic [1:0]  ack_src;

    modport master (
        input  req_valid, req_write, req_addr, req_src,
        output req_ready,
        input  wdata_valid, wdata,
        output wdata_ready,
        output rdata_valid, rdata,
        input  rdata_ready,
        output done, done_err,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready,
        input  ack_valid, ack_src,
        output ack_ready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_src,
        input  req_ready,
        output wdata_valid, wdata,
        input  wdata_ready,
        input  rdata_valid, rdata,
        output rdata_ready,
        input  done, done_err,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready,
        output ack_valid, ack_src,
        input  ack_ready
    );
endinterface

// File: rtl/mem_req_sequencer.sv
// Upstream request sequencer for mem_top: takes one client request, sends a
// header + 3 address bytes (+ payload for writes) on the tx bus, passes read
// payload from rx through to the client, then waits for the ack and pulses
// done / done_err. Read-data and ack waits are guarded by an idle timeout.
module mem_req_sequencer #(
    parameter int BLOCK_BYTES    = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_req_sequencer_if.master  bus
);

    localparam logic [7:0]  BLOCK_LAST    = 8'(BLOCK_BYTES);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_ACK,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic        write_reg;
    logic [23:0] addr_reg;
    logic [1:0]  src_reg;
    logic [7:0]  byte_cnt_reg, byte_cnt_next;
    logic [15:0] timer_reg, timer_next;
    logic        err_reg, err_next;

    logic        tx_fire;
    logic        rx_fire;
    logic [7:0]  byte_cnt_inc;
    logic [15:0] timer_inc;
    logic [7:0]  addr_bytes [0:2];

    // Address bytes in wire order: most significant first.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_addr_byte
            assign addr_bytes[gi] = addr_reg[23 - 8*gi -: 8];
        end
    endgenerate

    assign tx_fire      = bus.tx_valid && bus.tx_ready;
    assign rx_fire      = bus.rx_valid && bus.rx_ready;
    assign byte_cnt_inc = byte_cnt_reg + 8'd1;
    assign timer_inc    = timer_reg + 16'd1;

    // State register; reset aborts any transaction without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus next values of byte counter, idle timer and error flag.
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_next = S_HDR;
                    err_next   = 1'b0;
                end
            end
            S_HDR: begin
                if (tx_fire) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (tx_fire && byte_cnt_reg[1:0] == 2'd2)
                    state_next = write_reg ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                if (tx_fire && byte_cnt_inc == BLOCK_LAST) state_next = S_ACK;
            end
            S_RDATA: begin
                if (rx_fire) begin
                    if (byte_cnt_inc == BLOCK_LAST) state_next = S_ACK;
                end else if (timer_inc == TIMEOUT_LIMIT) begin
                    state_next = S_DONE;
                    err_next   = 1'b1;
                end
            end
            S_ACK: begin
                // A real ack wins over a timeout landing in the same cycle.
                if (bus.ack_valid) begin
                    state_next = S_DONE;
                    err_next   = (bus.ack_src != src_reg);
                end else if (timer_inc == TIMEOUT_LIMIT) begin
                    state_next = S_DONE;
                    err_next   = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Byte counter restarts on every state change so ADDR and the
        // payload phases each count from zero.
        if (state_next != state_reg) begin
            byte_cnt_next = 8'd0;
        end else if (tx_fire || rx_fire) begin
            byte_cnt_next = byte_cnt_inc;
        end else begin
            byte_cnt_next = byte_cnt_reg;
        end

        // Idle timer only runs while waiting on mem_top (read data or ack).
        if (state_next != state_reg || rx_fire) begin
            timer_next = 16'd0;
        end else if (state_reg == S_RDATA || state_reg == S_ACK) begin
            timer_next = timer_inc;
        end else begin
            timer_next = 16'd0;
        end
    end

    // Request fields latched at accept; counters and error flag advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_reg    <= 1'b0;
            addr_reg     <= 24'd0;
            src_reg      <= 2'd0;
            byte_cnt_reg <= 8'd0;
            timer_reg    <= 16'd0;
            err_reg      <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && bus.req_valid) begin
                write_reg <= bus.req_write;
                addr_reg  <= bus.req_addr;
                src_reg   <= bus.req_src;
            end
            byte_cnt_reg <= byte_cnt_next;
            timer_reg    <= timer_next;
            err_reg      <= err_next;
        end
    end

    // Handshake and data outputs; every output idles at 0 outside its state.
    always_comb begin
        bus.req_ready   = 1'b0;
        bus.tx_valid    = 1'b0;
        bus.tx_data     = 8'd0;
        bus.wdata_ready = 1'b0;
        bus.rdata_valid = 1'b0;
        bus.rdata       = 8'd0;
        bus.rx_ready    = 1'b0;
        bus.ack_ready   = 1'b0;
        bus.done        = 1'b0;
        bus.done_err    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                bus.req_ready = 1'b1;
            end
            S_HDR: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = {write_reg, 1'b0, src_reg, 4'b0000};
            end
            S_ADDR: begin
                bus.tx_valid = 1'b1;
                case (byte_cnt_reg[1:0])
                    2'd0:    bus.tx_data = addr_bytes[0];
                    2'd1:    bus.tx_data = addr_bytes[1];
                    default: bus.tx_data = addr_bytes[2];
                endcase
            end
            S_WDATA: begin
                bus.tx_valid    = bus.wdata_valid;
                bus.tx_data     = bus.wdata_valid ? bus.wdata : 8'd0;
                bus.wdata_ready = bus.tx_ready;
            end
            S_RDATA: begin
                bus.rdata_valid = bus.rx_valid;
                bus.rdata       = bus.rx_data;
                bus.rx_ready    = bus.rdata_ready;
            end
            S_ACK: begin
                bus.ack_ready = 1'b1;
            end
            S_DONE: begin
                bus.done     = 1'b1;
                bus.done_err = err_reg;
            end
            default: begin
                bus.req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer: one 32-byte instance with the long
// timeout and one single-byte instance with a short timeout.
module tb_mem_req_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_req_sequencer_if bus0();
    mem_req_sequencer_if bus1();

    mem_req_sequencer #(.BLOCK_BYTES(32), .TIMEOUT_CYCLES(4096)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mem_req_sequencer #(.BLOCK_BYTES(1), .TIMEOUT_CYCLES(16)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int errors = 0;
    int checks = 0;

    // Transfer logs captured mid-cycle, when all handshakes are stable.
    logic [7:0] txq0 [$];
    logic [7:0] txq1 [$];
    logic [7:0] rdq0 [$];
    int         done_cnt0 = 0;

    always @(negedge clk) begin
        if (bus0.tx_valid && bus0.tx_ready) txq0.push_back(bus0.tx_data);
        if (bus1.tx_valid && bus1.tx_ready) txq1.push_back(bus1.tx_data);
        if (bus0.rdata_valid && bus0.rdata_ready) rdq0.push_back(bus0.rdata);
        if (bus0.done) done_cnt0++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_src = 0;
        bus0.wdata_valid = 0; bus0.wdata = 0; bus0.rdata_ready = 0;
        bus0.tx_ready = 0; bus0.rx_valid = 0; bus0.rx_data = 0;
        bus0.ack_valid = 0; bus0.ack_src = 0;
        bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = 0; bus1.req_src = 0;
        bus1.wdata_valid = 0; bus1.wdata = 0; bus1.rdata_ready = 0;
        bus1.tx_ready = 0; bus1.rx_valid = 0; bus1.rx_data = 0;
        bus1.ack_valid = 0; bus1.ack_src = 0;
    endtask

    // Full 32-byte read on dut0 with every stream ready; rx bytes are 0..31.
    task automatic do_read(input string tg, input logic [23:0] addr, input logic [1:0] src,
                           input logic [7:0] exp_hdr, input logic [1:0] asrc, input logic exp_err);
        int base;
        int rbase;
        base  = txq0.size();
        rbase = rdq0.size();
        bus0.req_valid = 1; bus0.req_write = 0; bus0.req_addr = addr; bus0.req_src = src;
        bus0.tx_ready = 1; bus0.rdata_ready = 1;
        tick();
        bus0.req_valid = 0;
        settle();
        check({tg, "_hdr_valid"}, bus0.tx_valid, 1);
        check({tg, "_hdr"}, bus0.tx_data, exp_hdr);
        check({tg, "_req_ready_busy"}, bus0.req_ready, 0);
        for (int k = 0; k < 20 && bus0.rx_ready !== 1'b1; k++) tick();
        check({tg, "_rdata_entered"}, bus0.rx_ready, 1);
        check({tg, "_tx_count"}, txq0.size() - base, 4);
        check({tg, "_addr_hi"}, txq0[base+1], addr[23:16]);
        check({tg, "_addr_mid"}, txq0[base+2], addr[15:8]);
        check({tg, "_addr_lo"}, txq0[base+3], addr[7:0]);
        for (int i = 0; i < 32; i++) begin
            bus0.rx_valid = 1;
            bus0.rx_data  = 8'(i);
            settle();
            check({tg, "_rdata"}, bus0.rdata, 8'(i));
            tick();
        end
        bus0.rx_valid = 0;
        bus0.rx_data  = 0;
        settle();
        check({tg, "_rd_count"}, rdq0.size() - rbase, 32);
        check({tg, "_ack_ready"}, bus0.ack_ready, 1);
        check({tg, "_rx_ready_in_ack"}, bus0.rx_ready, 0);
        bus0.ack_valid = 1;
        bus0.ack_src   = asrc;
        tick();
        bus0.ack_valid = 0;
        settle();
        check({tg, "_done"}, bus0.done, 1);
        check({tg, "_done_err"}, bus0.done_err, exp_err);
        tick();
        settle();
        check({tg, "_req_ready_after"}, bus0.req_ready, 1);
        check({tg, "_done_cleared"}, bus0.done, 0);
    endtask

    initial begin
        int   base;
        int   wr_idx;
        int   d0;
        logic fire;

        zero_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        settle();
        // Reset state
        check("rst_req_ready", bus0.req_ready, 1);
        check("rst_done", bus0.done, 0);
        check("rst_done_err", bus0.done_err, 0);
        check("rst_tx_valid", bus0.tx_valid, 0);
        check("rst_tx_data", bus0.tx_data, 0);
        check("rst_rx_ready", bus0.rx_ready, 0);
        check("rst_ack_ready", bus0.ack_ready, 0);
        check("rst_wdata_ready", bus0.wdata_ready, 0);
        check("rst_rdata_valid", bus0.rdata_valid, 0);
        check("rst1_req_ready", bus1.req_ready, 1);

        // Read 0x123456, src 2: header 0x20, ack src matches
        do_read("rd1", 24'h123456, 2'd2, 8'h20, 2'd2, 1'b0);

        // Write 0x000100, src 1, wdata toggling and random tx stalls
        base = txq0.size();
        bus0.req_valid = 1; bus0.req_write = 1; bus0.req_addr = 24'h000100; bus0.req_src = 2'd1;
        tick();
        bus0.req_valid = 0;
        wr_idx = 0;
        for (int k = 0; k < 2000 && bus0.ack_ready !== 1'b1; k++) begin
            bus0.wdata_valid = k[0];
            bus0.wdata       = bus0.wdata_valid ? 8'(8'hA0 + wr_idx) : 8'h00;
            bus0.tx_ready    = 1'($urandom_range(0, 1));
            settle();
            fire = bus0.wdata_valid && bus0.wdata_ready;
            tick();
            if (fire) wr_idx++;
        end
        bus0.wdata_valid = 0;
        bus0.wdata = 0;
        bus0.tx_ready = 1;
        settle();
        check("wr_ack_reached", bus0.ack_ready, 1);
        check("wr_payload_accepted", wr_idx, 32);
        check("wr_tx_count", txq0.size() - base, 36);
        check("wr_hdr", txq0[base], 8'h90);
        check("wr_addr_hi", txq0[base+1], 8'h00);
        check("wr_addr_mid", txq0[base+2], 8'h01);
        check("wr_addr_lo", txq0[base+3], 8'h00);
        for (int i = 0; i < 32; i++) check("wr_payload", txq0[base+4+i], 8'(8'hA0 + i));
        bus0.ack_valid = 1;
        bus0.ack_src   = 2'd1;
        tick();
        bus0.ack_valid = 0;
        settle();
        check("wr_done", bus0.done, 1);
        check("wr_done_err", bus0.done_err, 0);
        tick();

        // Read timeout: rx stops after 10 bytes
        bus0.req_valid = 1; bus0.req_write = 0; bus0.req_addr = 24'h00ABCD; bus0.req_src = 2'd3;
        bus0.tx_ready = 1; bus0.rdata_ready = 1;
        tick();
        bus0.req_valid = 0;
        for (int k = 0; k < 20 && bus0.rx_ready !== 1'b1; k++) tick();
        check("to_rdata_entered", bus0.rx_ready, 1);
        for (int i = 0; i < 10; i++) begin
            bus0.rx_valid = 1;
            bus0.rx_data  = 8'(i);
            tick();
        end
        bus0.rx_valid = 0;
        d0 = done_cnt0;
        repeat (4095) tick();
        settle();
        check("to_not_yet_done", bus0.done, 0);
        check("to_no_early_pulse", done_cnt0 - d0, 0);
        check("to_still_rdata", bus0.rx_ready, 1);
        tick();
        settle();
        check("to_done", bus0.done, 1);
        check("to_done_err", bus0.done_err, 1);
        bus0.rx_valid = 1;
        settle();
        check("to_rx_ready_done", bus0.rx_ready, 0);
        check("to_rdata_valid_done", bus0.rdata_valid, 0);
        tick();
        settle();
        check("to_rx_ready_idle", bus0.rx_ready, 0);
        check("to_req_ready_idle", bus0.req_ready, 1);
        bus0.rx_valid = 0;

        // Reset during the 5th write payload byte
        bus0.req_valid = 1; bus0.req_write = 1; bus0.req_addr = 24'h000200; bus0.req_src = 2'd0;
        bus0.tx_ready = 1; bus0.wdata_valid = 1; bus0.wdata = 8'hC0;
        tick();
        bus0.req_valid = 0;
        repeat (8) tick();
        settle();
        check("rstmid_in_wdata", bus0.wdata_ready, 1);
        d0 = done_cnt0;
        rst_n = 0;
        tick();
        rst_n = 1;
        settle();
        check("rstmid_req_ready", bus0.req_ready, 1);
        check("rstmid_tx_valid", bus0.tx_valid, 0);
        check("rstmid_tx_data", bus0.tx_data, 0);
        check("rstmid_wdata_ready", bus0.wdata_ready, 0);
        check("rstmid_ack_ready", bus0.ack_ready, 0);
        check("rstmid_done", bus0.done, 0);
        bus0.wdata_valid = 0;
        repeat (3) tick();
        check("rstmid_no_done_pulse", done_cnt0 - d0, 0);
        do_read("rd2", 24'h00AA55, 2'd0, 8'h00, 2'd0, 1'b0);

        // BLOCK_BYTES=1 write, ack waiting early with wrong src (3 vs 0)
        base = txq1.size();
        bus1.req_valid = 1; bus1.req_write = 1; bus1.req_addr = 24'hABCDEF; bus1.req_src = 2'd0;
        bus1.tx_ready = 1; bus1.wdata_valid = 1; bus1.wdata = 8'h5A;
        bus1.ack_valid = 1; bus1.ack_src = 2'd3; bus1.rdata_ready = 1;
        tick();
        bus1.req_valid = 0;
        repeat (5) tick();
        settle();
        check("b1_ack_state", bus1.ack_ready, 1);
        check("b1_no_done_yet", bus1.done, 0);
        check("b1_tx_count", txq1.size() - base, 5);
        check("b1_hdr", txq1[base], 8'h80);
        check("b1_addr_hi", txq1[base+1], 8'hAB);
        check("b1_addr_mid", txq1[base+2], 8'hCD);
        check("b1_addr_lo", txq1[base+3], 8'hEF);
        check("b1_payload", txq1[base+4], 8'h5A);
        tick();
        settle();
        check("b1_done", bus1.done, 1);
        check("b1_done_err", bus1.done_err, 1);
        check("b1_req_ready_in_done", bus1.req_ready, 0);
        bus1.ack_valid = 0; bus1.wdata_valid = 0;
        // Request raised during DONE must wait for IDLE
        bus1.req_valid = 1; bus1.req_write = 0; bus1.req_addr = 24'h000001; bus1.req_src = 2'd1;
        tick();
        settle();
        check("b1_req_ready_back", bus1.req_ready, 1);
        check("b1_not_accepted_in_done", bus1.tx_valid, 0);
        tick();
        bus1.req_valid = 0;
        settle();
        check("b1_rd_hdr_valid", bus1.tx_valid, 1);
        check("b1_rd_hdr", bus1.tx_data, 8'h10);
        repeat (4) tick();
        settle();
        check("b1_rd_rdata", bus1.rx_ready, 1);
        bus1.rx_valid = 1;
        bus1.rx_data  = 8'h77;
        settle();
        check("b1_rd_byte", bus1.rdata, 8'h77);
        tick();
        bus1.rx_valid = 0;
        settle();
        check("b1_rd_in_ack", bus1.ack_ready, 1);
        repeat (15) tick();
        settle();
        check("b1_ack_wait", bus1.done, 0);
        tick();
        settle();
        check("b1_ack_timeout_done", bus1.done, 1);
        check("b1_ack_timeout_err", bus1.done_err, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
